// File: rtl/instr_feeder_if.sv
// rtl/instr_feeder_if.sv - processor-side instruction port bundle for instr_feeder
interface instr_feeder_if #(
  parameter int AW = 4
);
  logic [15:0]   inn;
  logic [AW-1:0] pc;
  logic          cpu_hold;
  logic          done;
  logic [15:0]   bus;

  modport master (output inn, pc, cpu_hold, input done, bus);
  modport slave  (input inn, pc, cpu_hold, output done, bus);
endinterface

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - program-memory instruction sequencer with completion watchdog
module instr_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WDOG  = 15
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [15:0]    wr_data,
  input  logic [AW:0]    prog_len,
  input  logic           start,
  input  logic           abort,
  instr_feeder_if.master cpu,
  output logic           busy,
  output logic           halted,
  output logic           fault,
  output logic [15:0]    last_bus
);

  localparam int          WW        = $clog2(WDOG + 1);
  localparam logic [AW:0] DEPTH_L   = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT,
    S_FAULT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   len_q;
  logic [WW-1:0] wdog;
  logic [AW-1:0] pc_q;
  logic [15:0]   inn_q;
  logic          idle_like;
  logic          len_ok;
  logic          last_instr;
  logic          wdog_exp;

  // States in which the processor is parked and the program may be reloaded.
  assign idle_like  = (state == S_IDLE) || (state == S_HALT) || (state == S_FAULT);
  assign len_ok     = (prog_len != '0) && (prog_len <= DEPTH_L);
  assign last_instr = (({1'b0, pc_q}) + (AW + 1)'(1)) == len_q;
  // The counter holds the number of ISSUE cycles already spent without done,
  // so seeing WDOG-1 here means this is the WDOG-th such cycle.
  assign wdog_exp   = (wdog == WDOG_LAST);

  assign cpu.inn      = inn_q;
  assign cpu.pc       = pc_q;
  assign cpu.cpu_hold = idle_like;
  assign busy         = (state == S_FETCH) || (state == S_ISSUE);
  assign halted       = (state == S_HALT);
  assign fault        = (state == S_FAULT);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; abort overrides everything, done beats watchdog expiry.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_FAULT: begin
          if (start) begin
            state_nx = len_ok ? S_FETCH : S_FAULT;
          end
        end
        S_FETCH: state_nx = S_ISSUE;
        S_ISSUE: begin
          if (cpu.done) begin
            state_nx = last_instr ? S_HALT : S_FETCH;
          end else if (wdog_exp) begin
            state_nx = S_FAULT;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Sequencer datapath: pc, presented instruction, watchdog, length and bus capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      inn_q    <= '0;
      wdog     <= '0;
      len_q    <= '0;
      last_bus <= '0;
    end else if (abort) begin
      pc_q  <= '0;
      inn_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_FAULT: begin
          if (start && len_ok) begin
            len_q <= prog_len;
            pc_q  <= '0;
          end
        end
        S_FETCH: begin
          inn_q <= mem[pc_q];
          wdog  <= '0;
        end
        S_ISSUE: begin
          if (cpu.done) begin
            last_bus <= cpu.bus;
            if (last_instr) begin
              inn_q <= '0;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end else begin
            wdog <= wdog + 1'b1;
            if (wdog_exp) begin
              inn_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Program memory; only writable while no program is running, never reset.
  always_ff @(posedge clock) begin
    if (wr_en && idle_like) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - randomized scoreboard bench for instr_feeder
module tb_instr_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int WDOG  = 15;

  // kind: 0 = instruction completion, 1 = run settled (not busy), 2 = reset seen
  typedef struct {
    int            kind;
    int            cyc;
    logic [15:0]   inn;
    logic [AW-1:0] pc;
    logic          halted;
    logic          fault;
    logic [15:0]   last_bus;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          abort;
  logic          busy;
  logic          halted;
  logic          fault;
  logic [15:0]   last_bus;

  instr_feeder_if #(.AW(AW)) cpu_bus ();

  instr_feeder #(.DEPTH(DEPTH), .AW(AW), .WDOG(WDOG)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .prog_len (prog_len),
    .start    (start),
    .abort    (abort),
    .cpu      (cpu_bus),
    .busy     (busy),
    .halted   (halted),
    .fault    (fault),
    .last_bus (last_bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          total = 0;
  int          bad   = 0;
  exp_t        q[$];
  logic [15:0] ref_mem [DEPTH];
  int          k_tab [DEPTH];
  logic [15:0] bus_tab [DEPTH];
  int          m_pc   = 0;
  logic [15:0] m_last = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic take(input int kind, input string name, output exp_t e, output bit ok);
    total++;
    ok = 1'b0;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s: got event kind %0d want nothing queued (cycle %0d)", name, kind, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind) begin
        bad++;
        $display("FAIL %s: got event kind %0d want kind %0d (cycle %0d)", name, kind, e.kind, cyc);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  function automatic void push(input int kind, input int c, input logic [15:0] i, input int p,
                               input logic h, input logic f, input logic [15:0] lb);
    exp_t e;
    e.kind = kind; e.cyc = c; e.inn = i; e.pc = AW'(p);
    e.halted = h; e.fault = f; e.last_bus = lb;
    q.push_back(e);
  endfunction

  task automatic tick();
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    ref_mem[a] = d;
    tick();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    push(1, cyc + 1, '0, 0, 1'b0, 1'b0, m_last);
    m_pc = 0;
    tick();
    abort = 1'b0;
  endtask

  // stop_at: index that never completes (watchdog), or that is hit by abort+done when abort_hit.
  task automatic run_prog(input int len, input int stop_at, input bit abort_hit,
                          input bit lock_wr, input bit wr_start);
    int s;
    int t;
    if (wr_start) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = 16'($urandom);
      ref_mem[0] = wr_data;
    end
    prog_len = (AW + 1)'(len);
    start = 1'b1;
    s = cyc + 1;
    if (len < 1 || len > DEPTH) begin
      push(1, s, '0, m_pc, 1'b0, 1'b1, m_last);
      tick();
      start = 1'b0;
      return;
    end
    // Expected timeline: each instruction costs its done delay plus one FETCH cycle.
    t = s;
    for (int i = 0; i < len; i++) begin
      if (i == stop_at && !abort_hit) begin
        push(1, t + 1 + WDOG, '0, i, 1'b0, 1'b1, m_last);
        m_pc = i;
        break;
      end
      push(0, 0, ref_mem[i], i, 1'b0, 1'b0, '0);
      if (i == stop_at) begin
        push(1, t + 1 + k_tab[i], '0, 0, 1'b0, 1'b0, m_last);
        m_pc = 0;
        break;
      end
      t += k_tab[i] + 1;
      m_last = bus_tab[i];
      if (i == len - 1) begin
        push(1, t, '0, i, 1'b1, 1'b0, m_last);
        m_pc = i;
      end
    end
    tick();
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (lock_wr && i == 0) begin
        wr_en = 1'b1; wr_addr = AW'(1); wr_data = ~ref_mem[1];
      end
      if (i == stop_at && !abort_hit) begin
        repeat (WDOG + 2) tick();
        break;
      end
      repeat (k_tab[i] - 1) tick();
      cpu_bus.done = 1'b1;
      cpu_bus.bus  = bus_tab[i];
      if (i == stop_at) abort = 1'b1;
      tick();
      cpu_bus.done = 1'b0;
      abort = 1'b0;
      if (i == stop_at) break;
    end
    tick();
  endtask

  task automatic randomize_tabs();
    for (int i = 0; i < DEPTH; i++) begin
      k_tab[i]   = $urandom_range(1, 4);
      bus_tab[i] = 16'($urandom);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin : monitor
    logic [2:0] prev;
    logic [2:0] cur;
    logic       prev_rst;
    exp_t       e;
    bit         ok;
    prev = 3'b000;
    prev_rst = 1'b1;
    forever begin
      @(negedge clock);
      #1;
      cur = {busy, halted, fault};
      if (!reset) begin
        if (prev_rst) begin
          take(2, "reset_event", e, ok);
          if (ok) begin
            chk("rst_inn", cpu_bus.inn, e.inn);
            chk("rst_pc", cpu_bus.pc, e.pc);
            chk("rst_hold", cpu_bus.cpu_hold, 1);
            chk("rst_busy", busy, 0);
            chk("rst_halted", halted, e.halted);
            chk("rst_fault", fault, e.fault);
            chk("rst_last_bus", last_bus, e.last_bus);
          end
        end
      end else begin
        if (cpu_bus.done && busy) begin
          take(0, "completion_event", e, ok);
          if (ok) begin
            chk("issue_inn", cpu_bus.inn, e.inn);
            chk("issue_pc", cpu_bus.pc, e.pc);
          end
        end
        if (cur != prev && !busy) begin
          take(1, "settle_event", e, ok);
          if (ok) begin
            chk("settle_cycle", cyc, e.cyc);
            chk("settle_halted", halted, e.halted);
            chk("settle_fault", fault, e.fault);
            chk("settle_pc", cpu_bus.pc, e.pc);
            chk("settle_last_bus", last_bus, e.last_bus);
            chk("settle_inn", cpu_bus.inn, 0);
            chk("settle_hold", cpu_bus.cpu_hold, 1);
          end
        end
      end
      prev = cur;
      prev_rst = reset;
    end
  end

  initial begin : stimulus
    int len;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;
    start = 1'b0; abort = 1'b0; cpu_bus.done = 1'b0; cpu_bus.bus = '0;
    push(2, 0, '0, 0, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) wr(i, 16'($urandom));

    // Basic run: three fixed words, done two cycles into each ISSUE.
    wr(0, 16'h1001); wr(1, 16'h2002); wr(2, 16'h3003);
    for (int i = 0; i < 3; i++) begin
      k_tab[i] = 2;
      bus_tab[i] = 16'h00A0 + 16'(i);
    end
    run_prog(3, -1, 1'b0, 1'b0, 1'b0);

    // Watchdog on a single-instruction program.
    run_prog(1, 0, 1'b0, 1'b0, 1'b0);

    // Bad lengths, each from IDLE.
    do_abort();
    run_prog(0, -1, 1'b0, 1'b0, 1'b0);
    do_abort();
    run_prog(DEPTH + 1, -1, 1'b0, 1'b0, 1'b0);
    do_abort();

    // Write lockout during ISSUE, then the same write while halted.
    randomize_tabs();
    run_prog(3, -1, 1'b0, 1'b1, 1'b0);
    wr(1, 16'hBEEF);
    run_prog(3, -1, 1'b0, 1'b0, 1'b0);

    // Abort colliding with done.
    randomize_tabs();
    run_prog(4, 1, 1'b1, 1'b0, 1'b0);

    // Random programs, some with a write alongside start, one hitting the watchdog.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, DEPTH);
      randomize_tabs();
      if (r % 3 == 1) wr($urandom_range(0, DEPTH - 1), 16'($urandom));
      run_prog(len, (r == 5) ? $urandom_range(0, len - 1) : -1, 1'b0, 1'b0, r[0]);
    end

    // Asynchronous reset in the middle of ISSUE, then a clean run.
    prog_len = (AW + 1)'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    push(2, 0, '0, 0, 1'b0, 1'b0, '0);
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    #3 reset = 1'b1;
    m_pc = 0;
    m_last = '0;
    randomize_tabs();
    run_prog(5, -1, 1'b0, 1'b0, 1'b0);

    repeat (4) tick();
    chk("leftover_events", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
